// File: rtl/channel_pkg.sv
// rtl/channel_pkg.sv - shared types and constants for the channel impairment blocks
package channel_pkg;

    typedef enum logic [1:0] {IDLE, CLEAN, NOISY} state_t;

    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam int          SAMPLE_MAX = 65535;
    localparam int          SAMPLE_MIN = -65536;

endpackage

// File: rtl/channel_lfsr.sv
// rtl/channel_lfsr.sv - 32-bit Galois LFSR noise source, steps once per advance pulse
module channel_lfsr
    import channel_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [31:0] state
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/channel_noise_scheduler.sv
// rtl/channel_noise_scheduler.sv - alternates clean and noisy periods on two FSK sample streams
module channel_noise_scheduler
    import channel_pkg::*;
#(
    parameter int          DATA_W    = 17,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_amp_shift,
    input  logic [CNT_W-1:0]  cfg_clean_len,
    input  logic [CNT_W-1:0]  cfg_noisy_len,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] input_1,
    input  logic [DATA_W-1:0] input_2,
    output logic              out_valid,
    output logic [DATA_W-1:0] output_1,
    output logic [DATA_W-1:0] output_2,
    output logic              noisy,
    output logic [15:0]       sat_count
);

    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(SAMPLE_MAX);
    localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(SAMPLE_MIN);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   clean_len_q, noisy_len_q;
    logic [CNT_W-1:0]   eff_clean, eff_noisy;
    logic [3:0]         shift_q;
    logic               cfg_take;
    logic [31:0]        lfsr;

    logic               out_valid_q, noisy_q;
    logic [DATA_W-1:0]  out1_q, out2_q;
    logic [15:0]        sat_q;

    logic signed [15:0] n1, n2;
    logic [DATA_W:0]    sum1, sum2;
    logic               sat1, sat2;
    logic [DATA_W-1:0]  res1, res2;

    assign cfg_ready = (state_q == IDLE);
    assign cfg_take  = cfg_valid && cfg_ready;
    // A config written in the same IDLE cycle as enable must shape the first period.
    assign eff_clean = cfg_take ? cfg_clean_len : clean_len_q;
    assign eff_noisy = cfg_take ? cfg_noisy_len : noisy_len_q;

    channel_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (in_valid),
        .state   (lfsr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (eff_clean == '0 && eff_noisy != '0) begin
                        state_d = NOISY;
                        cnt_d   = eff_noisy - CNT_ONE;
                    end else begin
                        state_d = CLEAN;
                        cnt_d   = eff_clean - CNT_ONE;
                    end
                end
            end
            CLEAN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (noisy_len_q != '0) begin
                        state_d = NOISY;
                        cnt_d   = noisy_len_q - CNT_ONE;
                    end else begin
                        cnt_d = clean_len_q - CNT_ONE;
                    end
                end
            end
            NOISY: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (clean_len_q != '0) begin
                        state_d = CLEAN;
                        cnt_d   = clean_len_q - CNT_ONE;
                    end else begin
                        cnt_d = noisy_len_q - CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Overflow of the widened sum shows up as disagreement of its top two bits.
    always_comb begin
        n1   = $signed(lfsr[15:0]) >>> shift_q;
        n2   = $signed(lfsr[31:16]) >>> shift_q;
        sum1 = {input_1[DATA_W-1], input_1} + {{(DATA_W-15){n1[15]}}, n1};
        sum2 = {input_2[DATA_W-1], input_2} + {{(DATA_W-15){n2[15]}}, n2};
        sat1 = sum1[DATA_W] ^ sum1[DATA_W-1];
        sat2 = sum2[DATA_W] ^ sum2[DATA_W-1];
        res1 = sat1 ? (sum1[DATA_W] ? SAT_MIN : SAT_MAX) : sum1[DATA_W-1:0];
        res2 = sat2 ? (sum2[DATA_W] ? SAT_MIN : SAT_MAX) : sum2[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            clean_len_q <= '0;
            noisy_len_q <= '0;
            shift_q     <= 4'd15;
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            out2_q      <= '0;
            noisy_q     <= 1'b0;
            sat_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= in_valid;
            if (cfg_take) begin
                clean_len_q <= cfg_clean_len;
                noisy_len_q <= cfg_noisy_len;
                shift_q     <= cfg_amp_shift;
            end
            if (in_valid) begin
                if (state_q == NOISY) begin
                    out1_q  <= res1;
                    out2_q  <= res2;
                    noisy_q <= 1'b1;
                    if ((sat1 || sat2) && sat_q != 16'hFFFF) begin
                        sat_q <= sat_q + 16'd1;
                    end
                end else begin
                    out1_q  <= input_1;
                    out2_q  <= input_2;
                    noisy_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign output_1  = out1_q;
    assign output_2  = out2_q;
    assign noisy     = noisy_q;
    assign sat_count = sat_q;

endmodule
